multiport_reg_file: RTL and testbench

- Parametrised successor to the single-issue register file.
- Provides NUM_RD combinational read ports, two write ports (wr0 = ALU writeback, wr1 = load/late writeback) and same-cycle write-to-read bypass.
- Holds a per-register pending scoreboard so decode can detect RAW hazards against in-flight instructions.
- Sits between decode (reads, issue marking) and the writeback stages.

---
 rtl/multiport_reg_file_if.sv | 35 +++
 rtl/multiport_reg_file.sv | 88 ++++++++
 tb/tb_multiport_reg_file.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/multiport_reg_file_if.sv
// Register file bus: read ports, two writeback ports, issue scoreboard.
// Master is the pipeline side, slave is the register file.
interface multiport_reg_file_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr0_en;
   logic [ADDR_W-1:0]        wr0_addr;
   logic [DATA_W-1:0]        wr0_data;
   logic                     wr1_en;
   logic [ADDR_W-1:0]        wr1_addr;
   logic [DATA_W-1:0]        wr1_data;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     flush;
   logic [ADDR_W:0]          pending_cnt;

   modport master (
      output rd_addr, wr0_en, wr0_addr, wr0_data,
      output wr1_en, wr1_addr, wr1_data,
      output iss_en, iss_addr, flush,
      input  rd_data, rd_busy, pending_cnt
   );

   modport slave (
      input  rd_addr, wr0_en, wr0_addr, wr0_data,
      input  wr1_en, wr1_addr, wr1_data,
      input  iss_en, iss_addr, flush,
      output rd_data, rd_busy, pending_cnt
   );
endinterface

// File: rtl/multiport_reg_file.sv
// Multi-read, dual-write register file with write-to-read bypass
// and a per-register pending scoreboard for RAW hazard detection.
module multiport_reg_file #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter bit ZERO_REG = 1'b1
) (
   input logic                  clk,
   input logic                  rst,
   multiport_reg_file_if.slave  bus
);
   localparam int NUM_REGS = 2**ADDR_W;

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pend_nxt;
   logic [ADDR_W:0]     cnt;
   logic [ADDR_W:0]     cnt_nxt;
   logic                w0;
   logic                w1;
   logic                iss;

   // Qualified enables: address 0 is inert when hardwired to zero
   always_comb begin
      w0  = bus.wr0_en && !(ZERO_REG && bus.wr0_addr == '0);
      w1  = bus.wr1_en && !(ZERO_REG && bus.wr1_addr == '0);
      iss = bus.iss_en && !(ZERO_REG && bus.iss_addr == '0);
   end

   // Storage commit; wr1 is applied last so it wins a same-address clash
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         if (w0) regs[bus.wr0_addr] <= bus.wr0_data;
         if (w1) regs[bus.wr1_addr] <= bus.wr1_data;
      end
   end

   // Next pending vector: flush > issue > write-clear, plus its popcount
   always_comb begin
      pend_nxt = pending;
      if (w0) pend_nxt[bus.wr0_addr] = 1'b0;
      if (w1) pend_nxt[bus.wr1_addr] = 1'b0;
      if (iss) pend_nxt[bus.iss_addr] = 1'b1;
      if (bus.flush) pend_nxt = '0;
      cnt_nxt = '0;
      for (int i = 0; i < NUM_REGS; i++)
         cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[i]};
   end

   // Scoreboard and count registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending <= '0;
         cnt     <= '0;
      end else begin
         pending <= pend_nxt;
         cnt     <= cnt_nxt;
      end
   end

   // Read ports with bypass from both writeback ports
   always_comb begin
      bus.rd_data = '0;
      bus.rd_busy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         logic [ADDR_W-1:0] a;
         logic              h0;
         logic              h1;
         a  = bus.rd_addr[k*ADDR_W +: ADDR_W];
         h0 = w0 && bus.wr0_addr == a;
         h1 = w1 && bus.wr1_addr == a;
         if (ZERO_REG && a == '0)
            bus.rd_data[k*DATA_W +: DATA_W] = '0;
         else if (h1)
            bus.rd_data[k*DATA_W +: DATA_W] = bus.wr1_data;
         else if (h0)
            bus.rd_data[k*DATA_W +: DATA_W] = bus.wr0_data;
         else
            bus.rd_data[k*DATA_W +: DATA_W] = regs[a];
         bus.rd_busy[k] = pending[a] && !(h0 || h1);
      end
   end

   assign bus.pending_cnt = cnt;
endmodule

// File: tb/tb_multiport_reg_file.sv
// Directed-vector bench for multiport_reg_file.
// Inputs change 1 time unit after the rising edge, outputs sampled later.
module tb_multiport_reg_file;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   multiport_reg_file_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

   multiport_reg_file #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.wr0_en = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
      bus.wr1_en = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
      bus.iss_en = 1'b0; bus.iss_addr = '0; bus.flush = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      bus.rd_addr = {a1, a0};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [DW-1:0] d0, d1;
   assign d0 = bus.rd_data[0 +: DW];
   assign d1 = bus.rd_data[DW +: DW];

   initial begin
      idle();
      rd(5'd3, 5'd0);
      // reset held while a write and issue are presented
      bus.wr0_en = 1'b1; bus.wr0_addr = 5'd3; bus.wr0_data = 32'h99;
      bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
      repeat (2) tick();
      check("cnt_in_rst", bus.pending_cnt, 0);
      idle();
      #2 rst = 1'b1;
      #1;
      check("rst_d0", d0, 0);
      check("rst_d1", d1, 0);
      check("rst_busy", bus.rd_busy, 0);
      check("rst_cnt", bus.pending_cnt, 0);

      // write to r0 is discarded
      tick();
      bus.wr0_en = 1'b1; bus.wr0_addr = 5'd0; bus.wr0_data = 32'hDEADBEEF;
      #1 check("r0_same", d1, 0);
      tick();
      idle();
      #1 check("r0_after", d1, 0);

      // bypass from wr0
      rd(5'd5, 5'd0);
      bus.wr0_en = 1'b1; bus.wr0_addr = 5'd5; bus.wr0_data = 32'h1234;
      #1 check("byp_same", d0, 32'h1234);
      tick();
      idle();
      #1 check("byp_store", d0, 32'h1234);

      // dual write conflict, wr1 wins
      rd(5'd7, 5'd5);
      bus.wr0_en = 1'b1; bus.wr0_addr = 5'd7; bus.wr0_data = 32'hAAAA;
      bus.wr1_en = 1'b1; bus.wr1_addr = 5'd7; bus.wr1_data = 32'h5555;
      #1 check("dual_same", d0, 32'h5555);
      tick();
      idle();
      #1 check("dual_store", d0, 32'h5555);
      check("r5_kept", d1, 32'h1234);

      // scoreboard issue then wr1 retire
      rd(5'd9, 5'd0);
      bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
      #1 check("iss_same_busy", bus.rd_busy[0], 0);
      tick();
      idle();
      #1 check("sb_busy", bus.rd_busy[0], 1);
      check("sb_cnt1", bus.pending_cnt, 1);
      bus.wr1_en = 1'b1; bus.wr1_addr = 5'd9; bus.wr1_data = 32'h42;
      #1 check("sb_wr_busy", bus.rd_busy[0], 0);
      check("sb_wr_data", d0, 32'h42);
      tick();
      idle();
      #1 check("sb_cnt0", bus.pending_cnt, 0);

      // issue to r0 is ignored
      bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
      tick();
      idle();
      #1 check("iss_r0_cnt", bus.pending_cnt, 0);

      // issue and write collide on r4
      rd(5'd4, 5'd0);
      bus.iss_en = 1'b1; bus.iss_addr = 5'd4;
      bus.wr0_en = 1'b1; bus.wr0_addr = 5'd4; bus.wr0_data = 32'h77;
      tick();
      idle();
      #1 check("col_data", d0, 32'h77);
      check("col_busy", bus.rd_busy[0], 1);
      check("col_cnt", bus.pending_cnt, 1);
      bus.wr1_en = 1'b1; bus.wr1_addr = 5'd4; bus.wr1_data = 32'h78;
      tick();
      idle();
      #1 check("col_clr", bus.pending_cnt, 0);

      // flush drops pending bits and a same-cycle issue
      for (int i = 1; i <= 3; i++) begin
         bus.iss_en = 1'b1; bus.iss_addr = AW'(i);
         tick();
      end
      idle();
      #1 check("fl_cnt3", bus.pending_cnt, 3);
      rd(5'd1, 5'd2);
      #1 check("fl_busy_pre", bus.rd_busy, 2'b11);
      bus.flush = 1'b1;
      bus.iss_en = 1'b1; bus.iss_addr = 5'd6;
      tick();
      idle();
      #1 check("fl_cnt0", bus.pending_cnt, 0);
      check("fl_busy12", bus.rd_busy, 0);
      rd(5'd3, 5'd6);
      #1 check("fl_busy36", bus.rd_busy, 0);

      // asynchronous reset mid-run clears scoreboard at once
      rd(5'd8, 5'd7);
      bus.iss_en = 1'b1; bus.iss_addr = 5'd8;
      tick();
      idle();
      #1 check("ar_cnt1", bus.pending_cnt, 1);
      rst = 1'b0;
      #1 check("ar_cnt0", bus.pending_cnt, 0);
      check("ar_busy", bus.rd_busy, 0);
      check("ar_data", d1, 0);
      rst = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
